// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: walks T1..T6 per instruction and decodes the IR opcode
// into datapath strobes, with free-run/single-step pacing and a sticky HALT.
module sap1_controller #(
    parameter bit         SKIP_NOP = 1'b0,
    parameter logic [3:0] OP_LDA   = 4'h0,
    parameter logic [3:0] OP_ADD   = 4'h1,
    parameter logic [3:0] OP_SUB   = 4'h2,
    parameter logic [3:0] OP_OUT   = 4'hE,
    parameter logic [3:0] OP_HLT   = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       step_mode,
    input  logic       step,
    output logic       pc_inc,
    output logic       mar_sel,
    output logic       mar_load,
    output logic       ir_load,
    output logic       b_load,
    output logic       out_load,
    output logic       Eacc,
    output logic       LaccM,
    output logic       LaccA,
    output logic       alu_sub,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [6:0] {
        S_T1   = 7'b0000001,
        S_T2   = 7'b0000010,
        S_T3   = 7'b0000100,
        S_T4   = 7'b0001000,
        S_T5   = 7'b0010000,
        S_T6   = 7'b0100000,
        S_HALT = 7'b1000000
    } state_t;

    state_t state;
    state_t state_next;
    logic   step_q;
    logic   advance;
    logic   is_lda, is_add, is_sub, is_out, is_hlt, is_known;

    // A held step level advances exactly once: only its rising edge counts.
    assign advance = ~step_mode | (step & ~step_q);

    assign is_lda   = (opcode == OP_LDA);
    assign is_add   = (opcode == OP_ADD);
    assign is_sub   = (opcode == OP_SUB);
    assign is_out   = (opcode == OP_OUT);
    assign is_hlt   = (opcode == OP_HLT);
    assign is_known = is_lda | is_add | is_sub | is_out | is_hlt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_T1;
            step_q <= 1'b0;
        end else begin
            state  <= state_next;
            step_q <= step;
        end
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pc_inc     = 1'b0;
        mar_sel    = 1'b0;
        mar_load   = 1'b0;
        ir_load    = 1'b0;
        b_load     = 1'b0;
        out_load   = 1'b0;
        Eacc       = 1'b0;
        LaccM      = 1'b0;
        LaccA      = 1'b0;
        alu_sub    = 1'b0;

        case (state)
            S_T1: begin
                mar_load   = 1'b1;
                state_next = S_T2;
            end
            S_T2: begin
                pc_inc     = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                ir_load    = 1'b1;
                state_next = (SKIP_NOP && !is_known) ? S_T1 : S_T4;
            end
            S_T4: begin
                mar_load   = is_lda | is_add | is_sub;
                mar_sel    = is_lda | is_add | is_sub;
                out_load   = is_out;
                if (is_hlt)
                    state_next = S_HALT;
                else
                    state_next = (SKIP_NOP && is_out) ? S_T1 : S_T5;
            end
            S_T5: begin
                Eacc       = is_lda;
                LaccM      = is_lda;
                b_load     = is_add | is_sub;
                state_next = (SKIP_NOP && is_lda) ? S_T1 : S_T6;
            end
            S_T6: begin
                Eacc       = is_add | is_sub;
                LaccA      = is_add | is_sub;
                alu_sub    = is_sub;
                state_next = S_T1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_T1;
        endcase

        // Stalled or reset cycles hold the state and issue no strobes at all.
        if (!(advance && rst_n)) begin
            state_next = state;
            pc_inc     = 1'b0;
            mar_sel    = 1'b0;
            mar_load   = 1'b0;
            ir_load    = 1'b0;
            b_load     = 1'b0;
            out_load   = 1'b0;
            Eacc       = 1'b0;
            LaccM      = 1'b0;
            LaccA      = 1'b0;
            alu_sub    = 1'b0;
        end
    end

    assign t_state = rst_n ? state[5:0] : 6'b000001;
    assign halted  = rst_n & state[6];

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: two instances (SKIP_NOP = 0 and 1) checked every cycle
// against a step-count reference model, with directed scenarios then random traffic.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       step_mode;
    logic       step;

    // Strobe vector order: {pc_inc, mar_sel, mar_load, ir_load, b_load, out_load, Eacc, LaccM, LaccA, alu_sub}
    wire [9:0] str0, str1;
    wire [5:0] ts0, ts1;
    wire       h0, h1;

    int total = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: position within the instruction (1..6), halt flag, previous step.
    int m_t [2];
    bit m_h [2];
    bit m_sq;

    always #5 clk = ~clk;

    sap1_controller #(.SKIP_NOP(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .step_mode(step_mode), .step(step),
        .pc_inc(str0[9]), .mar_sel(str0[8]), .mar_load(str0[7]), .ir_load(str0[6]),
        .b_load(str0[5]), .out_load(str0[4]), .Eacc(str0[3]), .LaccM(str0[2]),
        .LaccA(str0[1]), .alu_sub(str0[0]), .t_state(ts0), .halted(h0)
    );

    sap1_controller #(.SKIP_NOP(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .step_mode(step_mode), .step(step),
        .pc_inc(str1[9]), .mar_sel(str1[8]), .mar_load(str1[7]), .ir_load(str1[6]),
        .b_load(str1[5]), .out_load(str1[4]), .Eacc(str1[3]), .LaccM(str1[2]),
        .LaccA(str1[1]), .alu_sub(str1[0]), .t_state(ts1), .halted(h1)
    );

    // Micro-operations an instruction performs at step t.
    function automatic logic [9:0] uops(int t, logic [3:0] op);
        logic [9:0] u;
        u = '0;
        case (t)
            1: u = 10'b0010000000;
            2: u = 10'b1000000000;
            3: u = 10'b0001000000;
            4: if (op inside {4'h0, 4'h1, 4'h2}) u = 10'b0110000000;
               else if (op == 4'hE)             u = 10'b0000010000;
            5: if (op == 4'h0)                  u = 10'b0000001100;
               else if (op inside {4'h1, 4'h2}) u = 10'b0000100000;
            6: if (op == 4'h1)                  u = 10'b0000001010;
               else if (op == 4'h2)             u = 10'b0000001011;
            default: u = '0;
        endcase
        return u;
    endfunction

    // Last step that does useful work for an opcode.
    function automatic int last_step(logic [3:0] op);
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            4'hE:       return 4;
            4'hF:       return 6;
            default:    return 3;
        endcase
    endfunction

    function automatic bit model_advance();
        return !step_mode || (step && !m_sq);
    endfunction

    task automatic check(string tag, int d, logic [9:0] obs, logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s skip=%0d cycle=%0d observed=%b expected=%b", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [9:0] e_str;
        logic [5:0] e_ts;
        logic       e_h;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                e_str = '0;
                e_ts  = 6'b000001;
                e_h   = 1'b0;
            end else if (m_h[d]) begin
                e_str = '0;
                e_ts  = '0;
                e_h   = 1'b1;
            end else begin
                e_str = model_advance() ? uops(m_t[d], opcode) : 10'b0;
                e_ts  = 6'(1 << (m_t[d] - 1));
                e_h   = 1'b0;
            end
            check("strobes", d, (d == 0) ? str0 : str1, e_str);
            check("t_state", d, {4'b0, (d == 0) ? ts0 : ts1}, {4'b0, e_ts});
            check("halted",  d, {9'b0, (d == 0) ? h0 : h1}, {9'b0, e_h});
        end
    endtask

    task automatic model_update();
        bit adv;
        adv = model_advance();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_t[d] = 1;
                m_h[d] = 1'b0;
            end else if (!m_h[d] && adv) begin
                if (m_t[d] == 4 && opcode == 4'hF)
                    m_h[d] = 1'b1;
                else if (m_t[d] == 6 || (d == 1 && m_t[d] == last_step(opcode)))
                    m_t[d] = 1;
                else
                    m_t[d] = m_t[d] + 1;
            end
        end
        m_sq = rst_n ? step : 1'b0;
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 4'h0;
        step_mode = 1'b0;
        step      = 1'b0;
        m_t[0]    = 1;
        m_t[1]    = 1;
        m_h[0]    = 1'b0;
        m_h[1]    = 1'b0;
        m_sq      = 1'b0;
        @(negedge clk);

        // LDA in free-run: full fetch/execute sequence, then back to T1.
        tick();
        rst_n = 1'b1;
        repeat (7) tick();

        // SUB then ADD.
        do_reset();
        opcode = 4'h2;
        repeat (6) tick();
        opcode = 4'h1;
        repeat (6) tick();

        // HLT holds through step activity until reset.
        do_reset();
        opcode = 4'hF;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            step      = i[0];
            step_mode = i[2];
            tick();
        end
        step_mode = 1'b0;
        step      = 1'b0;
        do_reset();
        tick();

        // Single-step: a held step level advances only once.
        step_mode = 1'b1;
        step      = 1'b1;
        opcode    = 4'h0;
        do_reset();
        repeat (10) tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        repeat (2) tick();
        step      = 1'b0;
        step_mode = 1'b0;

        // Short instructions with early return to T1.
        do_reset();
        opcode = 4'hE;
        repeat (8) tick();
        do_reset();
        opcode = 4'h0;
        repeat (10) tick();
        do_reset();
        opcode = 4'h7;
        repeat (6) tick();

        // Reset during T5 of ADD abandons the instruction.
        do_reset();
        opcode = 4'h1;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (8) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0) && !(m_h[0] && m_h[1] && $urandom_range(0, 3) == 0);
            step_mode = ($urandom_range(0, 2) == 0);
            step      = $urandom_range(0, 1);
            opcode    = 4'($urandom_range(0, 15));
            if (opcode == 4'hF && $urandom_range(0, 3) != 0)
                opcode = 4'h1;
            tick();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
